// File: rtl/rv6_pkg.sv
// Shared RV32 opcode constants and register-usage decode helpers.
// Used by the hazard controller and its per-stage decoders.
package rv6_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_AMO      = 7'b0101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes;
    logic       rs1_used;
    logic       rs2_used;
    logic       is_load;
  } regdec_t;

  // x0 never counts as a destination; ecall/ebreak have a junk rd field
  function automatic logic dec_writes(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return (ir[11:7] != 5'd0)
        && (op != OPC_BRANCH)
        && (op != OPC_STORE)
        && (op != OPC_MISC_MEM)
        && !((op == OPC_SYSTEM) && (ir[14:12] == 3'd0));
  endfunction

  function automatic logic dec_rs1_used(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic dec_rs2_used(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return op inside {OPC_OP, OPC_OP32, OPC_BRANCH,
                      OPC_STORE, OPC_AMO};
  endfunction

endpackage

// File: rtl/rv_regdec.sv
// Register-field decoder for one instruction.
// Produces rd/rs fields and their validity flags.
module rv_regdec
  import rv6_pkg::*;
(
  input  logic [31:0] i_ir,
  output regdec_t     o_dec
);

  // pure field extraction plus usage flags
  always_comb begin
    o_dec          = '0;
    o_dec.rd       = i_ir[11:7];
    o_dec.rs1      = i_ir[19:15];
    o_dec.rs2      = i_ir[24:20];
    o_dec.writes   = dec_writes(i_ir);
    o_dec.rs1_used = dec_rs1_used(i_ir);
    o_dec.rs2_used = dec_rs2_used(i_ir);
    o_dec.is_load  = (i_ir[6:0] == OPC_LOAD);
  end

endmodule

// File: rtl/hazard_ctl.sv
// RAW interlock controller: stall, bubble and forward selects
// for an ID stage followed by DEPTH tracked stages.
module hazard_ctl
  import rv6_pkg::*;
#(
  parameter  int DEPTH      = 3,
  parameter  int FWD        = 0,
  parameter  int LOAD_STAGE = 1,
  parameter  int N_BUS      = 3,
  localparam int SW         = $clog2(DEPTH + 1),
  localparam int CW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_ir_id,
  input  logic [32*DEPTH-1:0]   i_ir_pipe,
  input  logic [N_BUS-1:0]      i_bus_busy,
  output logic                  o_stall_fe,
  output logic                  o_stall_be,
  output logic                  o_bubble_ex,
  output logic [SW-1:0]         o_fwd_rs1,
  output logic [SW-1:0]         o_fwd_rs2,
  output logic [31:0]           o_hz_stall_cnt
);

  regdec_t          w_id;
  regdec_t          w_st [DEPTH];
  logic [DEPTH-1:0] w_m1;
  logic [DEPTH-1:0] w_m2;

  logic [SW-1:0]    w_sel1;
  logic [SW-1:0]    w_sel2;
  logic [SW-1:0]    w_selA;
  logic             w_ld1;
  logic             w_ld2;

  logic             w_h1;
  logic             w_h2;
  logic [SW-1:0]    w_hsel;
  logic             w_det;
  logic [CW-1:0]    w_ldv;

  logic             w_hz;
  logic             w_be;
  logic             w_fe;
  logic             w_bub;
  logic             w_fz;

  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_hz_cnt;

  rv_regdec u_id (
    .i_ir  (i_ir_id),
    .o_dec (w_id)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    rv_regdec u_dec (
      .i_ir  (i_ir_pipe[32*g +: 32]),
      .o_dec (w_st[g])
    );
    assign w_m1[g] = w_id.rs1_used & w_st[g].writes
                   & (w_st[g].rd == w_id.rs1);
    assign w_m2[g] = w_id.rs2_used & w_st[g].writes
                   & (w_st[g].rd == w_id.rs2);
  end

  // lowest-index match per source; selects encoded as k+1
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    w_selA = '0;
    w_ld1  = 1'b0;
    w_ld2  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_m1[k]) begin
        w_sel1 = SW'(k + 1);
        w_ld1  = w_st[k].is_load;
      end
      if (w_m2[k]) begin
        w_sel2 = SW'(k + 1);
        w_ld2  = w_st[k].is_load;
      end
      if (w_m1[k] | w_m2[k]) begin
        w_selA = SW'(k + 1);
      end
    end
  end

  // hazard detection and stall length for the current mode
  always_comb begin
    w_h1   = 1'b0;
    w_h2   = 1'b0;
    w_hsel = '0;
    w_det  = 1'b0;
    w_ldv  = '0;
    if (FWD == 0) begin
      w_det = (w_selA != '0);
      w_ldv = CW'(DEPTH - int'(w_selA));
    end else begin
      w_h1  = (w_sel1 != '0) & w_ld1
            & (int'(w_sel1) <= LOAD_STAGE);
      w_h2  = (w_sel2 != '0) & w_ld2
            & (int'(w_sel2) <= LOAD_STAGE);
      w_det = w_h1 | w_h2;
      if (w_h1 && (!w_h2 || (w_sel1 <= w_sel2))) begin
        w_hsel = w_sel1;
      end else begin
        w_hsel = w_sel2;
      end
      w_ldv = CW'(LOAD_STAGE - int'(w_hsel));
    end
  end

  // detection is masked while a stall is already running
  always_comb begin
    w_hz  = w_det & (r_cnt == '0);
    w_be  = i_rst | (|i_bus_busy);
    w_fe  = w_be | w_hz | (r_cnt != '0);
    w_bub = w_fe & ~w_be;
    w_fz  = i_rst | w_hz | (r_cnt != '0);
  end

  assign o_stall_be  = w_be;
  assign o_stall_fe  = w_fe;
  assign o_bubble_ex = w_bub;
  assign o_fwd_rs1   = (FWD != 0 && !w_fz) ? w_sel1 : '0;
  assign o_fwd_rs2   = (FWD != 0 && !w_fz) ? w_sel2 : '0;
  assign o_hz_stall_cnt = r_hz_cnt;

  // remaining hazard stall cycles, frozen while the bus is busy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!w_be) begin
      if (w_hz) begin
        r_cnt <= w_ldv;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // performance counter of hazard bubbles, wraps naturally
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hz_cnt <= '0;
    end else if (w_bub) begin
      r_hz_cnt <= r_hz_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: u0 interlock-only, u1 forwarding.
// Pipeline is modelled so stalls shift real instructions.
module tb_hazard_ctl;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OP32  = 7'b0111011;
  localparam logic [6:0] AMO   = 7'b0101111;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam logic [6:0] MISC  = 7'b0001111;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam int         LS    = 1;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst_s  [2];
  logic [2:0]  busy_s [2];
  logic [31:0] id_s   [2];
  logic [95:0] pipe_s [2];
  logic        fe  [2];
  logic        be  [2];
  logic        bub [2];
  logic [1:0]  f1  [2];
  logic [1:0]  f2  [2];
  logic [31:0] hz  [2];

  logic [31:0] m_id   [2];
  logic [31:0] m_pipe [2][3];

  int n_chk = 0;
  int n_err = 0;

  hazard_ctl #(.DEPTH(3), .FWD(0), .LOAD_STAGE(1), .N_BUS(3)) u0 (
    .i_clk(clk), .i_rst(rst_s[0]), .i_ir_id(id_s[0]),
    .i_ir_pipe(pipe_s[0]), .i_bus_busy(busy_s[0]),
    .o_stall_fe(fe[0]), .o_stall_be(be[0]),
    .o_bubble_ex(bub[0]), .o_fwd_rs1(f1[0]),
    .o_fwd_rs2(f2[0]), .o_hz_stall_cnt(hz[0])
  );

  hazard_ctl #(.DEPTH(3), .FWD(1), .LOAD_STAGE(LS), .N_BUS(3)) u1 (
    .i_clk(clk), .i_rst(rst_s[1]), .i_ir_id(id_s[1]),
    .i_ir_pipe(pipe_s[1]), .i_bus_busy(busy_s[1]),
    .o_stall_fe(fe[1]), .o_stall_be(be[1]),
    .o_bubble_ex(bub[1]), .o_fwd_rs1(f1[1]),
    .o_fwd_rs2(f2[1]), .o_hz_stall_cnt(hz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(
    input logic [6:0] op, input logic [4:0] rd,
    input logic [2:0] f3, input logic [4:0] rs1,
    input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, rd, op};
  endfunction

  // reference decode, written independently of the design
  function automatic logic r_wr(input logic [31:0] x);
    if (x[11:7] == 5'd0) return 1'b0;
    case (x[6:0])
      BR, STORE, MISC: return 1'b0;
      SYS:             return x[14:12] != 3'd0;
      default:         return 1'b1;
    endcase
  endfunction

  function automatic logic r_u1(input logic [31:0] x);
    return !(x[6:0] == LUI || x[6:0] == AUIPC || x[6:0] == JAL);
  endfunction

  function automatic logic r_u2(input logic [31:0] x);
    case (x[6:0])
      OP, OP32, BR, STORE, AMO: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  // nearest in-flight writer of rs, or -1
  function automatic int nearest(input int s, input logic [4:0] rs,
                                 input logic used);
    if (!used) return -1;
    for (int k = 0; k < 3; k++)
      if (r_wr(m_pipe[s][k]) && m_pipe[s][k][11:7] == rs) return k;
    return -1;
  endfunction

  // stall while ID needs a value that is not yet obtainable
  task automatic ref_m(input int s, input logic [2:0] b,
                       output logic efe, output logic ebe,
                       output logic ebub, output logic [1:0] ef1,
                       output logic [1:0] ef2);
    int  k1, k2;
    logic h;
    k1 = nearest(s, m_id[s][19:15], r_u1(m_id[s]));
    k2 = nearest(s, m_id[s][24:20], r_u2(m_id[s]));
    if (s == 0) h = (k1 >= 0) || (k2 >= 0);
    else h = (k1 >= 0 && k1 < LS && m_pipe[s][k1][6:0] == LOAD)
          || (k2 >= 0 && k2 < LS && m_pipe[s][k2][6:0] == LOAD);
    ebe  = (b != 3'd0);
    efe  = ebe || h;
    ebub = efe && !ebe;
    ef1  = (s == 1 && !h && k1 >= 0) ? 2'(k1 + 1) : 2'd0;
    ef2  = (s == 1 && !h && k2 >= 0) ? 2'(k2 + 1) : 2'd0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int s, input logic r, input logic [2:0] b);
    @(negedge clk);
    rst_s[s]  = r;
    busy_s[s] = b;
    id_s[s]   = m_id[s];
    pipe_s[s] = {m_pipe[s][2], m_pipe[s][1], m_pipe[s][0]};
    #4;
  endtask

  // datapath reaction to the controller's outputs
  task automatic adv(input int s, input logic [31:0] nid);
    if (!fe[s] || !be[s]) begin
      m_pipe[s][2] = m_pipe[s][1];
      m_pipe[s][1] = m_pipe[s][0];
      m_pipe[s][0] = fe[s] ? NOP : m_id[s];
      if (!fe[s]) m_id[s] = nid;
    end
  endtask

  task automatic flush(input int s);
    m_id[s] = NOP;
    for (int k = 0; k < 3; k++) m_pipe[s][k] = NOP;
  endtask

  task automatic reset_dut(input int s);
    flush(s);
    cyc(s, 1'b1, 3'd0);
  endtask

  function automatic logic [31:0] rnd_ir();
    logic [6:0]  ops [13];
    logic [31:0] x;
    ops = '{OPIMM, LUI, AUIPC, JAL, JALR, LOAD, STORE,
            BR, OP, OP32, AMO, SYS, MISC};
    x        = $urandom;
    x[6:0]   = ops[$urandom_range(0, 12)];
    x[11:7]  = 5'($urandom_range(0, 3));
    x[19:15] = 5'($urandom_range(0, 3));
    x[24:20] = 5'($urandom_range(0, 3));
    return x;
  endfunction

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ex;
    logic [31:0] mem;
    logic [31:0] wb;
    logic [2:0]  busy;
    logic        fe0;
    logic        bub0;
    logic        fe1;
    logic        bub1;
    logic [1:0]  ef1;
    logic [1:0]  ef2;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(
    input logic [31:0] id, ex, mem, wb, input logic [2:0] b,
    input logic a0, a1, a2, a3, input logic [1:0] a4, a5);
    vec_t v;
    v = '{id, ex, mem, wb, b, a0, a1, a2, a3, a4, a5};
    return v;
  endfunction

  initial begin : main
    logic [31:0] add3_12, addi1, addi2, lw5, add7, addi0;
    logic [31:0] add3_00, beq1, add3_11, lui4, sw21, addi_r2;
    logic [31:0] stx1, ecall1, csr1, jal1;
    logic [5:0]  fev, bubv;
    logic [1:0]  cv [4];
    logic        efe, ebe, ebub;
    logic [1:0]  ef1, ef2;
    logic [31:0] eh;
    logic [2:0]  b;

    add3_12 = enc(OP, 3, 0, 1, 2);
    addi1   = enc(OPIMM, 1, 0, 0, 5);
    addi2   = enc(OPIMM, 2, 0, 0, 0);
    lw5     = enc(LOAD, 5, 2, 6, 0);
    add7    = enc(OP, 7, 0, 5, 0);
    addi0   = enc(OPIMM, 0, 0, 1, 1);
    add3_00 = enc(OP, 3, 0, 0, 0);
    beq1    = enc(BR, 1, 0, 2, 3);
    add3_11 = enc(OP, 3, 0, 1, 1);
    lui4    = enc(LUI, 4, 0, 1, 0);
    sw21    = enc(STORE, 0, 2, 2, 1);
    addi_r2 = enc(OPIMM, 3, 0, 0, 2);
    stx1    = enc(STORE, 1, 2, 0, 0);
    ecall1  = enc(SYS, 1, 0, 0, 0);
    csr1    = enc(SYS, 1, 1, 0, 0);
    jal1    = enc(JAL, 3, 0, 1, 0);

    tv.push_back(mk(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(add3_12, addi1, NOP, NOP, 0, 1, 1, 0, 0, 1, 0));
    tv.push_back(mk(add3_12, NOP, addi1, NOP, 0, 1, 1, 0, 0, 2, 0));
    tv.push_back(mk(add3_12, NOP, NOP, addi1, 0, 1, 1, 0, 0, 3, 0));
    tv.push_back(mk(add3_12, addi2, addi1, NOP, 0, 1, 1, 0, 0, 2, 1));
    tv.push_back(mk(add3_12, addi1, addi1, addi2, 0, 1, 1, 0, 0, 1, 3));
    tv.push_back(mk(add7, lw5, NOP, NOP, 0, 1, 1, 1, 1, 0, 0));
    tv.push_back(mk(add7, NOP, lw5, NOP, 0, 1, 1, 0, 0, 2, 0));
    tv.push_back(mk(add3_00, addi0, NOP, NOP, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(add3_11, beq1, NOP, NOP, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(lui4, addi1, addi0, NOP, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(sw21, addi1, NOP, NOP, 0, 1, 1, 0, 0, 0, 1));
    tv.push_back(mk(addi_r2, addi2, NOP, NOP, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(add3_12, addi1, NOP, NOP, 2, 1, 0, 1, 0, 1, 0));
    tv.push_back(mk(add3_11, stx1, ecall1, NOP, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(add3_11, csr1, NOP, NOP, 0, 1, 1, 0, 0, 1, 1));
    tv.push_back(mk(jal1, addi1, NOP, NOP, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(add7, lw5, NOP, NOP, 1, 1, 0, 1, 0, 0, 0));

    for (int s = 0; s < 2; s++) begin
      flush(s);
      rst_s[s] = 1'b1;
      busy_s[s] = 3'd0;
      id_s[s] = NOP;
      pipe_s[s] = {3{NOP}};
    end

    // reset state
    for (int s = 0; s < 2; s++) begin
      reset_dut(s);
      cyc(s, 1'b1, 3'd0);
      chk($sformatf("rst%0d_fe", s), 32'(fe[s]), 1);
      chk($sformatf("rst%0d_be", s), 32'(be[s]), 1);
      chk($sformatf("rst%0d_bub", s), 32'(bub[s]), 0);
      chk($sformatf("rst%0d_f1", s), 32'(f1[s]), 0);
      chk($sformatf("rst%0d_f2", s), 32'(f2[s]), 0);
      chk($sformatf("rst%0d_hz", s), hz[s], 0);
    end

    // single-cycle decode vectors on a freshly reset controller
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        rst_s[s] = 1'b1;
        busy_s[s] = 3'd0;
        id_s[s] = NOP;
        pipe_s[s] = {3{NOP}};
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        rst_s[s] = 1'b0;
        busy_s[s] = tv[i].busy;
        id_s[s] = tv[i].id;
        pipe_s[s] = {tv[i].wb, tv[i].mem, tv[i].ex};
      end
      #4;
      chk($sformatf("v%0d_fe0", i), 32'(fe[0]), 32'(tv[i].fe0));
      chk($sformatf("v%0d_bub0", i), 32'(bub[0]), 32'(tv[i].bub0));
      chk($sformatf("v%0d_fwd0", i), 32'({f1[0], f2[0]}), 0);
      chk($sformatf("v%0d_fe1", i), 32'(fe[1]), 32'(tv[i].fe1));
      chk($sformatf("v%0d_bub1", i), 32'(bub[1]), 32'(tv[i].bub1));
      chk($sformatf("v%0d_f1", i), 32'(f1[1]), 32'(tv[i].ef1));
      chk($sformatf("v%0d_f2", i), 32'(f2[1]), 32'(tv[i].ef2));
    end

    // interlock: EX producer gives three stall cycles
    reset_dut(0);
    m_id[0] = add3_12;
    m_pipe[0][0] = addi1;
    cv = '{2'd0, 2'd2, 2'd1, 2'd0};
    fev = '0;
    bubv = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 3'd0);
      fev[i] = fe[0];
      bubv[i] = bub[0];
      chk($sformatf("seq_cnt%0d", i), 32'(u0.r_cnt), 32'(cv[i]));
      adv(0, NOP);
    end
    chk("seq3_fe", 32'(fev), 32'h7);
    chk("seq3_bub", 32'(bubv), 32'h7);
    chk("seq3_hz", hz[0], 3);

    // forwarding: same pair, then producer one stage later
    reset_dut(1);
    m_id[1] = add3_12;
    m_pipe[1][0] = addi1;
    cyc(1, 1'b0, 3'd0);
    chk("fw_fe", 32'(fe[1]), 0);
    chk("fw_f1_ex", 32'(f1[1]), 1);
    chk("fw_f2_ex", 32'(f2[1]), 0);
    adv(1, add3_12);
    cyc(1, 1'b0, 3'd0);
    chk("fw_f1_mem", 32'(f1[1]), 2);
    chk("fw_f2_mem", 32'(f2[1]), 0);

    // load-use costs exactly one bubble
    reset_dut(1);
    m_id[1] = add7;
    m_pipe[1][0] = lw5;
    cyc(1, 1'b0, 3'd0);
    chk("lu_fe0", 32'(fe[1]), 1);
    chk("lu_bub0", 32'(bub[1]), 1);
    chk("lu_f10", 32'(f1[1]), 0);
    adv(1, NOP);
    cyc(1, 1'b0, 3'd0);
    chk("lu_fe1", 32'(fe[1]), 0);
    chk("lu_f11", 32'(f1[1]), 2);
    chk("lu_f21", 32'(f2[1]), 0);
    chk("lu_hz", hz[1], 1);

    // bus busy inside a stall stretches it without bubbles
    reset_dut(0);
    m_id[0] = add3_12;
    m_pipe[0][0] = addi1;
    fev = '0;
    bubv = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'b0, (i == 1 || i == 2) ? 3'b010 : 3'b000);
      fev[i] = fe[0];
      bubv[i] = bub[0];
      adv(0, NOP);
    end
    chk("busy_fe", 32'(fev), 32'h1f);
    chk("busy_bub", 32'(bubv), 32'h19);
    chk("busy_hz", hz[0], 3);

    // reset in the middle of a stall abandons it
    reset_dut(0);
    m_id[0] = add3_12;
    m_pipe[0][0] = addi1;
    cyc(0, 1'b0, 3'd0);
    adv(0, NOP);
    cyc(0, 1'b1, 3'd0);
    chk("mrst_cnt_before", 32'(u0.r_cnt), 2);
    chk("mrst_fe", 32'(fe[0]), 1);
    chk("mrst_be", 32'(be[0]), 1);
    chk("mrst_bub", 32'(bub[0]), 0);
    flush(0);
    cyc(0, 1'b0, 3'd0);
    chk("mrst_cnt", 32'(u0.r_cnt), 0);
    chk("mrst_hz", hz[0], 0);
    chk("mrst_fe_after", 32'(fe[0]), 0);

    // random instruction stream against the pipeline-level model
    for (int s = 0; s < 2; s++) begin
      reset_dut(s);
      eh = 0;
      for (int t = 0; t < 400; t++) begin
        b = ($urandom_range(0, 6) == 0) ?
            3'($urandom_range(1, 7)) : 3'd0;
        cyc(s, 1'b0, b);
        ref_m(s, b, efe, ebe, ebub, ef1, ef2);
        chk($sformatf("r%0d_%0d_fe", s, t), 32'(fe[s]), 32'(efe));
        chk($sformatf("r%0d_%0d_be", s, t), 32'(be[s]), 32'(ebe));
        chk($sformatf("r%0d_%0d_bub", s, t), 32'(bub[s]), 32'(ebub));
        chk($sformatf("r%0d_%0d_f1", s, t), 32'(f1[s]), 32'(ef1));
        chk($sformatf("r%0d_%0d_f2", s, t), 32'(f2[s]), 32'(ef2));
        chk($sformatf("r%0d_%0d_hz", s, t), hz[s], eh);
        if (ebub) eh = eh + 1;
        adv(s, rnd_ir());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Parametrised pipeline interlock controller: detects read-after-write hazards between the instruction in ID and the instructions in the DEPTH stages after it, and generates stall, bubble and forwarding-select signals. Sits beside the datapath, replacing the fixed three-stage stall unit. Supports two modes: full interlock (no forwarding) and forwarding with load-use stall. Also keeps a hazard-stall performance counter.

## Interface
- DEPTH, 3: number of post-ID stages tracked (index 0 = EX, 1 = MEM, 2 = WB, ...); legal 2..6.
- FWD, 0: 0 = interlock-only mode, 1 = forwarding mode.
- LOAD_STAGE, 1: lowest stage index at which load data can be forwarded (FWD=1 only); legal 1..DEPTH-1.
- N_BUS, 3: number of bus-busy request lines.
- SW, $clog2(DEPTH+1): derived; forward-select width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ir_id  in  32  instruction in ID.
- ir_pipe  in  32*DEPTH  post-ID instructions; bits [32k+31:32k] = stage k.
- bus_busy  in  N_BUS  any bit high freezes the whole pipeline (instruction fetch, data read, data write).
- stall_fe  out  1  hold IF, PD, ID.
- stall_be  out  1  hold EX and later stages.
- bubble_ex  out  1  EX must latch a NOP this cycle.
- fwd_rs1, fwd_rs2  out  SW  0 = register file; k+1 = result of stage k.
- hz_stall_cnt  out  32  count of cycles stalled by data hazards.

## Operation
- Decode per instruction: writes = rd != 0 and opcode not BRANCH (1100011), STORE (0100011), MISC-MEM (0001111), or SYSTEM with funct3 = 0. rs1_used = opcode not LUI, AUIPC, JAL. rs2_used = opcode in OP, OP-32, BRANCH, STORE, AMO. is_load = opcode LOAD (0000011).
- Match(k, rsN) = rsN_used(ID) and writes(k) and rd(k) == rsN(ID).
- FWD=0: hazard = any match, k chosen as the lowest matching index. Total stall = DEPTH-k cycles. First cycle is combinational; counter loaded with DEPTH-1-k. While counter is nonzero, detection is masked.
- FWD=1: hazard only if the lowest-index match for rs1 or rs2 is a load with k < LOAD_STAGE. Counter loaded with LOAD_STAGE-1-k.
  - Otherwise fwd_rsN = k+1 for the lowest matching k; 0 if no match or the source is unused.
  - fwd_* are forced to 0 while stall_fe is high due to a hazard.
- stall_be = rst or |bus_busy.
- stall_fe = stall_be or hazard or (counter != 0).
- bubble_ex = stall_fe and not stall_be.
- Counter:
  - Loads only when hazard is detected and stall_be is low.
  - Decrements by 1 when nonzero and stall_be is low.
  - Holds otherwise.
- hz_stall_cnt increments when bubble_ex is high. Wraps at 2^32-1 to 0.

## Timing
- Reset values: counter 0, hz_stall_cnt 0. During rst, stall_fe=1, stall_be=1, bubble_ex=0, fwd_*=0.
- All outputs except counters are combinational from inputs and state. No output registers.
- FWD=0, DEPTH=3: match in EX gives 3 stall cycles, MEM gives 2, WB gives 1. Released on the cycle the counter reads 0.
- Bus busy during a stall freezes the counter. Stall length extends by exactly the busy cycles; bubble_ex is low during those cycles.
- Hazard and bus_busy in the same cycle: no counter load. Detection repeats on the first non-busy cycle.
- rst asserted mid-stall clears the counter at the next edge. The stall is abandoned.
- Counter width: $clog2(DEPTH).

## Structure
- Opcode constants and the three decode functions go in shared package rv6_pkg: OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP32, OPC_AMO, OPC_SYSTEM, OPC_MISC_MEM.
- One sub-module, rv_regdec. It decodes a single instruction to {rd, rs1, rs2, writes, rs1_used, rs2_used, is_load} and is instantiated DEPTH+1 times.
- Top level contains:
  - the generate loop for match and priority encoding;
  - the stall counter;
  - the performance counter.

## Test plan
- FWD=0, DEPTH=3:
  - ID `add x3,x1,x2`, EX `addi x1,x0,5` -> stall_fe=1 and bubble_ex=1 for 3 cycles; counter 2,1,0.
  - hz_stall_cnt +3.
- FWD=1: same pair -> no stall, fwd_rs1=1, fwd_rs2=0.
  - Next cycle, instruction in MEM -> fwd_rs1=2.
- FWD=1, LOAD_STAGE=1:
  - EX `lw x5,0(x6)`, ID `add x7,x5,x0` -> exactly 1 stall cycle.
  - Then fwd_rs1=2, and fwd_rs2=0 since x0 never matches.
- False dependencies, no stall in either mode:
  - EX `addi x0,x1,1`;
  - EX `beq` with bits [11:7]=1 and ID using x1;
  - ID `lui x4,1` with EX writing x0/x1.
- FWD=0, EX match, bus_busy[1]=1 for 2 cycles after the first stall cycle -> stall_fe lasts 5 cycles, bubble_ex high for 3, hz_stall_cnt +3.
- rst pulsed for 1 cycle while counter=2 -> counter 0, hz_stall_cnt 0.
  - Next cycle with no hazard: stall_fe=0.
